// File: rtl/ccg_bist_controller.sv
// ccg_bist_controller
//
// BIST sequencer for generated combinational benchmark circuits. A Galois
// LFSR drives the CUT input bus, each pattern is held for SETTLE_CYCLES
// cycles, and the CUT response is compacted into a Galois MISR on the last
// cycle of each window. After PATTERNS captures the signature is compared
// against golden_sig to produce a single pass bit.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         begin a run (honoured in IDLE or DONE only)
//   abort         cancel a run in progress / leave DONE
//   golden_sig    expected final signature
//   cut_out       CUT response word
//   cut_in        pattern driven to the CUT (0 when not busy)
//   busy          run in progress
//   done          run complete, pass valid
//   pass          final signature matched golden_sig
//   signature     current MISR contents
//   pattern_count patterns captured so far in this run
module ccg_bist_controller #(
  parameter int                N_IN          = 26,
  parameter int                N_OUT         = 30,
  parameter int                PATTERNS      = 1024,
  parameter int                SETTLE_CYCLES = 1,
  parameter logic [N_IN-1:0]   SEED          = N_IN'(1),
  parameter logic [N_IN-1:0]   LFSR_POLY     = N_IN'('h47),
  parameter logic [N_OUT-1:0]  MISR_POLY     = N_OUT'('h53),
  localparam int               CW            = $clog2(PATTERNS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] golden_sig,
  input  logic [N_OUT-1:0] cut_out,
  output logic [N_IN-1:0]  cut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_OUT-1:0] signature,
  output logic [CW-1:0]    pattern_count
);

  // Settle counter only has to reach SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0]   PAT_LAST    = CW'(PATTERNS - 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [N_IN-1:0] SEED_EFF    = (SEED == '0) ? N_IN'(1) : SEED;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_next;

  logic [N_IN-1:0]  lfsr;
  logic [N_IN-1:0]  lfsr_next;
  logic [N_OUT-1:0] sig_next;
  logic [SW-1:0]    settle;

  logic             load;       // start honoured this cycle
  logic             capture;    // last cycle of a settle window, not aborted
  logic             last_cap;   // capture of the final pattern

  // ---------------------------------------------------------------------
  // Next-value functions for the two shift registers.
  // ---------------------------------------------------------------------
  always_comb begin
    lfsr_next = {lfsr[N_IN-2:0], 1'b0} ^ (lfsr[N_IN-1] ? LFSR_POLY : '0);
    sig_next  = {signature[N_OUT-2:0], 1'b0}
              ^ (signature[N_OUT-1] ? MISR_POLY : '0)
              ^ cut_out;
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // abort beats a coincident capture; in DONE a new start beats abort so a
  // back-to-back rerun is never lost.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_RUN;
      S_RUN: begin
        if (abort)         state_next = S_IDLE;
        else if (last_cap) state_next = S_DONE;
      end
      S_DONE: begin
        if (start)         state_next = S_RUN;
        else if (abort)    state_next = S_IDLE;
      end
      default:             state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // ---------------------------------------------------------------------
  always_comb begin
    busy     = (state == S_RUN);
    done     = (state == S_DONE);
    load     = (state != S_RUN) && start;
    capture  = busy && !abort && (settle == SETTLE_LAST);
    last_cap = capture && (pattern_count == PAT_LAST);
    cut_in   = busy ? lfsr : '0;
  end

  // ---------------------------------------------------------------------
  // Datapath: LFSR, MISR, counters, pass flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr          <= '0;
      signature     <= '0;
      pattern_count <= '0;
      settle        <= '0;
      pass          <= 1'b0;
    end else if (load) begin
      lfsr          <= SEED_EFF;
      signature     <= '0;
      pattern_count <= '0;
      settle        <= '0;
      pass          <= 1'b0;
    end else if (busy && !abort) begin
      if (capture) begin
        lfsr          <= lfsr_next;
        signature     <= sig_next;
        pattern_count <= pattern_count + CW'(1);
        settle        <= '0;
        // Compare the signature including this final capture.
        if (last_cap) pass <= (sig_next == golden_sig);
      end else begin
        settle <= settle + SW'(1);
      end
    end else if (done && abort) begin
      pass <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ccg_bist_controller.sv
`timescale 1ns/1ps
module tb_ccg_bist_controller;

  localparam int NI = 26;
  localparam int NO = 30;
  localparam int FLIP_P = 100;
  localparam logic [NO-1:0] FLIP_M = 30'h0000_0400;

  typedef struct packed {
    logic [NO-1:0] sig;
    logic          pass;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: full-size run with a bench-modelled CUT
  logic          start_a = 0, abort_a = 0;
  logic [NO-1:0] golden_a = '0, flip_a = '0, cut_out_a;
  logic [NI-1:0] cut_in_a;
  logic          busy_a, done_a, pass_a;
  logic [NO-1:0] sig_a;
  logic [10:0]   cnt_a;

  // DUT B: two patterns, constant CUT response
  logic          start_b = 0, abort_b = 0;
  logic [NO-1:0] golden_b = '0, cut_out_b;
  logic [NI-1:0] cut_in_b;
  logic          busy_b, done_b, pass_b;
  logic [NO-1:0] sig_b;
  logic [1:0]    cnt_b;

  // DUT C: three-cycle settle, four patterns
  logic          start_c = 0, abort_c = 0;
  logic [NO-1:0] golden_c = '0, cut_out_c;
  logic [NI-1:0] cut_in_c;
  logic          busy_c, done_c, pass_c;
  logic [NO-1:0] sig_c;
  logic [2:0]    cnt_c;

  int vectors = 0;
  int miscompares = 0;

  logic [NI-1:0] exp_cut[$];
  res_t          exp_res[$];

  function automatic logic [NI-1:0] lfsr_step(input logic [NI-1:0] x);
    return {x[NI-2:0], 1'b0} ^ (x[NI-1] ? 26'h47 : 26'h0);
  endfunction

  function automatic logic [NO-1:0] misr_step(input logic [NO-1:0] s, input logic [NO-1:0] d);
    return {s[NO-2:0], 1'b0} ^ (s[NO-1] ? 30'h53 : 30'h0) ^ d;
  endfunction

  // Stand-in combinational CUT (mixes XOR and AND terms).
  function automatic logic [NO-1:0] cut_fn(input logic [NI-1:0] x);
    return {x[3:0] ^ x[25:22], x ^ ({x[12:0], x[25:13]} & {x[0], x[25:1]})};
  endfunction

  assign cut_out_a = cut_fn(cut_in_a) ^ flip_a;
  assign cut_out_b = 30'h0000_0001;
  assign cut_out_c = cut_fn(cut_in_c);

  ccg_bist_controller dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .golden_sig(golden_a),
    .cut_out(cut_out_a), .cut_in(cut_in_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .signature(sig_a), .pattern_count(cnt_a));

  ccg_bist_controller #(.PATTERNS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .golden_sig(golden_b),
    .cut_out(cut_out_b), .cut_in(cut_in_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .signature(sig_b), .pattern_count(cnt_b));

  ccg_bist_controller #(.PATTERNS(4), .SETTLE_CYCLES(3)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c), .golden_sig(golden_c),
    .cut_out(cut_out_c), .cut_in(cut_in_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .signature(sig_c), .pattern_count(cnt_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rst held 3 cycles with a coincident start: rst must win.
  task automatic test_reset();
    rst = 1; start_a = 1;
    repeat (3) tick();
    rst = 0; start_a = 0;
    vectors++;
    if ({busy_a, done_a, pass_a} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got=%b want=000", {busy_a, done_a, pass_a});
    end
    vectors++;
    if (cut_in_a !== '0 || sig_a !== '0 || cnt_a !== '0) begin
      miscompares++;
      $display("FAIL reset_regs got cut_in=%h sig=%h cnt=%0d want 0/0/0", cut_in_a, sig_a, cnt_a);
    end
  endtask

  // Full run on A; also checks the LFSR sequence cycle by cycle.
  task automatic test_live_cut(input bit flip);
    logic [NI-1:0] l;
    logic [NO-1:0] s, d;
    int n;
    l = 26'h1; s = '0;
    for (int p = 0; p < 1024; p++) begin
      exp_cut.push_back(l);
      d = cut_fn(l) ^ ((flip && p == FLIP_P) ? FLIP_M : '0);
      s = misr_step(s, d);
      l = lfsr_step(l);
    end
    if (!flip) golden_a = s;
    exp_res.push_back('{sig: s, pass: (s == golden_a)});

    start_a = 1; tick(); start_a = 0;
    for (int cyc = 0; cyc < 1024; cyc++) begin
      flip_a = (flip && cyc == FLIP_P) ? FLIP_M : '0;
      vectors++;
      if (busy_a !== 1'b1 || done_a !== 1'b0 || cnt_a !== 11'(cyc)) begin
        miscompares++;
        $display("FAIL live_busy cyc=%0d got busy=%b done=%b cnt=%0d want 1/0/%0d",
                 cyc, busy_a, done_a, cnt_a, cyc);
      end
      vectors++;
      if (cut_in_a !== exp_cut[0]) begin
        miscompares++; $display("FAIL lfsr_seq cyc=%0d got=%h want=%h", cyc, cut_in_a, exp_cut[0]);
      end
      void'(exp_cut.pop_front());
      if (cyc == 25) begin
        vectors++;
        if (cut_in_a !== 26'h2000000) begin
          miscompares++; $display("FAIL lfsr_p25 got=%h want=2000000", cut_in_a);
        end
      end
      if (cyc == 26) begin
        vectors++;
        if (cut_in_a !== 26'h0000047) begin
          miscompares++; $display("FAIL lfsr_p26 got=%h want=0000047", cut_in_a);
        end
      end
      tick();
    end
    flip_a = '0;
    n = 0;
    while (!done_a && n < 10) begin tick(); n++; end
    vectors++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || cnt_a !== 11'd1024) begin
      miscompares++;
      $display("FAIL live_done got done=%b busy=%b cnt=%0d want 1/0/1024", done_a, busy_a, cnt_a);
    end
    vectors++;
    if (sig_a !== exp_res[0].sig || pass_a !== exp_res[0].pass) begin
      miscompares++;
      $display("FAIL live_sig flip=%0d got sig=%h pass=%b want sig=%h pass=%b",
               flip, sig_a, pass_a, exp_res[0].sig, exp_res[0].pass);
    end
    void'(exp_res.pop_front());
  endtask

  // Abort during pattern 5, IDLE abort, restart, start-in-RUN ignored, mid-run reset.
  task automatic test_abort();
    logic [NO-1:0] s;
    logic [NI-1:0] l;
    l = 26'h1; s = '0;
    for (int p = 0; p < 5; p++) begin s = misr_step(s, cut_fn(l)); l = lfsr_step(l); end

    start_a = 1; tick(); start_a = 0;
    repeat (5) tick();
    vectors++;
    if (cnt_a !== 11'd5 || cut_in_a !== l) begin
      miscompares++; $display("FAIL abort_pre got cnt=%0d cut_in=%h want 5/%h", cnt_a, cut_in_a, l);
    end
    abort_a = 1; tick(); abort_a = 0;
    vectors++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || cnt_a !== 11'd5 || cut_in_a !== '0) begin
      miscompares++;
      $display("FAIL abort_state got busy=%b done=%b cnt=%0d cut_in=%h want 0/0/5/0",
               busy_a, done_a, cnt_a, cut_in_a);
    end
    vectors++;
    if (sig_a !== s) begin
      miscompares++; $display("FAIL abort_sig got=%h want=%h", sig_a, s);
    end
    abort_a = 1; tick(); abort_a = 0; tick();
    vectors++;
    if (busy_a !== 1'b0 || cnt_a !== 11'd5 || sig_a !== s) begin
      miscompares++;
      $display("FAIL idle_abort got busy=%b cnt=%0d sig=%h want 0/5/%h", busy_a, cnt_a, sig_a, s);
    end

    start_a = 1; tick();
    vectors++;
    if (busy_a !== 1'b1 || cut_in_a !== 26'h1 || cnt_a !== '0 || sig_a !== '0) begin
      miscompares++;
      $display("FAIL restart got busy=%b cut_in=%h cnt=%0d sig=%h want 1/1/0/0",
               busy_a, cut_in_a, cnt_a, sig_a);
    end
    tick(); start_a = 0;
    vectors++;
    if (cut_in_a !== 26'h2 || cnt_a !== 11'd1) begin
      miscompares++; $display("FAIL start_in_run got cut_in=%h cnt=%0d want 2/1", cut_in_a, cnt_a);
    end
    repeat (4) tick();
    rst = 1; repeat (3) tick(); rst = 0;
    vectors++;
    if ({busy_a, done_a, pass_a} !== 3'b000 || cut_in_a !== '0 || sig_a !== '0 || cnt_a !== '0) begin
      miscompares++;
      $display("FAIL reset_midrun got flags=%b cut_in=%h sig=%h cnt=%0d want all 0",
               {busy_a, done_a, pass_a}, cut_in_a, sig_a, cnt_a);
    end
  endtask

  // Two patterns with cut_out=1: signature 1 then 3.
  task automatic run_b(input logic [NO-1:0] golden, input logic exp_pass);
    int busy_n, n;
    golden_b = golden;
    exp_res.push_back('{sig: 30'h3, pass: exp_pass});
    start_b = 1; tick(); start_b = 0;
    busy_n = 0; n = 0;
    while (!done_b && n < 20) begin
      if (busy_b) busy_n++;
      tick(); n++;
    end
    vectors++;
    if (done_b !== 1'b1 || busy_n != 2 || cnt_b !== 2'd2) begin
      miscompares++;
      $display("FAIL misr_done got done=%b busy_cycles=%0d cnt=%0d want 1/2/2", done_b, busy_n, cnt_b);
    end
    vectors++;
    if (sig_b !== exp_res[0].sig || pass_b !== exp_res[0].pass) begin
      miscompares++;
      $display("FAIL misr_sig golden=%h got sig=%h pass=%b want sig=%h pass=%b",
               golden, sig_b, pass_b, exp_res[0].sig, exp_res[0].pass);
    end
    void'(exp_res.pop_front());
  endtask

  task automatic test_misr();
    run_b(30'h3, 1'b1);
    abort_b = 1; tick(); abort_b = 0;
    vectors++;
    if (done_b !== 1'b0 || pass_b !== 1'b0 || busy_b !== 1'b0) begin
      miscompares++;
      $display("FAIL done_abort got done=%b pass=%b busy=%b want 0/0/0", done_b, pass_b, busy_b);
    end
    run_b(30'h2, 1'b0);
    // back-to-back rerun straight from DONE
    run_b(30'h3, 1'b1);
  endtask

  // SETTLE_CYCLES=3, PATTERNS=4: 12 busy cycles, each pattern held 3.
  task automatic test_settle();
    logic [NI-1:0] l;
    logic [NO-1:0] s;
    int cyc;
    l = 26'h1; s = '0;
    for (int p = 0; p < 4; p++) begin
      repeat (3) exp_cut.push_back(l);
      s = misr_step(s, cut_fn(l));
      l = lfsr_step(l);
    end
    golden_c = s;
    start_c = 1; tick(); start_c = 0;
    cyc = 0;
    while (busy_c && cyc < 40) begin
      vectors++;
      if (exp_cut.size() == 0 || cut_in_c !== exp_cut[0] || cnt_c !== 3'(cyc / 3) || done_c !== 1'b0) begin
        miscompares++;
        $display("FAIL settle_hold cyc=%0d got cut_in=%h cnt=%0d done=%b want %h/%0d/0",
                 cyc, cut_in_c, cnt_c, done_c, (exp_cut.size() != 0) ? exp_cut[0] : '0, cyc / 3);
      end
      if (exp_cut.size() != 0) void'(exp_cut.pop_front());
      tick(); cyc++;
    end
    vectors++;
    if (cyc != 12) begin
      miscompares++; $display("FAIL settle_len got=%0d want=12", cyc);
    end
    vectors++;
    if (done_c !== 1'b1 || cnt_c !== 3'd4 || sig_c !== s || pass_c !== 1'b1) begin
      miscompares++;
      $display("FAIL settle_end got done=%b cnt=%0d sig=%h pass=%b want 1/4/%h/1",
               done_c, cnt_c, sig_c, pass_c, s);
    end
    exp_cut.delete();
  endtask

  initial begin
    test_reset();
    test_live_cut(1'b0);
    test_live_cut(1'b1);
    test_abort();
    test_misr();
    test_settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ccg_bist_controller.md
# ccg_bist_controller

Built-in self-test sequencer for the generated combinational benchmark circuits (CCGRCG family). It drives a circuit-under-test (CUT) input bus with an LFSR pseudo-random pattern stream, waits a programmable settle time per pattern, and compacts every captured CUT output word into a MISR signature. At the end of the run it compares the signature against a golden value, so a whole generated netlist can be checked in silicon or simulation with a single pass/fail bit.

## Interface
- N_IN, 26, CUT input width (LFSR width)
- N_OUT, 30, CUT output width (MISR width)
- PATTERNS, 1024, patterns applied per run (≥1)
- SETTLE_CYCLES, 1, cycles each pattern is held before capture (≥1)
- SEED, 1, LFSR start value; 0 is replaced by 1
- LFSR_POLY, 'h47, Galois feedback mask for the LFSR (x^26+x^6+x^2+x+1)
- MISR_POLY, 'h53, Galois feedback mask for the MISR (x^30+x^6+x^4+x+1)
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE or DONE only
- abort  in  1  cancel a run in progress
- golden_sig  in  N_OUT  expected final signature; must be stable while done=1
- cut_out  in  N_OUT  CUT response
- cut_in  out  N_IN  pattern to CUT
- busy  out  1  run in progress
- done  out  1  run complete, result valid
- pass  out  1  signature matched golden_sig (valid while done=1)
- signature  out  N_OUT  current MISR contents
- pattern_count  out  clog2(PATTERNS+1)  patterns captured so far

## Operation
- States: IDLE, RUN, DONE.
- Reset (any state, including mid-run): state=IDLE; lfsr, signature, pattern_count and settle counter=0; busy=done=pass=0; cut_in=0.
- cut_in = lfsr when busy, else 0.
- IDLE/DONE + start=1: lfsr←SEED (or 1), signature←0, pattern_count←0, settle←0, done←0, pass←0, state←RUN.
- RUN: settle increments each cycle. On the cycle with settle==SETTLE_CYCLES-1 (the capture edge):
  - signature ← {signature[N_OUT-2:0],0} ^ (signature[N_OUT-1] ? MISR_POLY : 0) ^ cut_out
  - lfsr ← {lfsr[N_IN-2:0],0} ^ (lfsr[N_IN-1] ? LFSR_POLY : 0)
  - pattern_count++, settle←0
  - if pattern_count==PATTERNS-1: state←DONE, pass←(new signature==golden_sig)
- RUN + abort=1: state←IDLE next edge, with no capture on that edge. done stays 0. signature, lfsr and pattern_count freeze at their pre-abort values.
- start during RUN is ignored. abort has priority over a coincident capture edge.
- DONE: done=1 and busy=0. Holds until start (new run) or abort (→IDLE, clears done/pass); signature holds.
- IDLE + abort: no effect.

## Timing
- busy rises on the edge after start is sampled; the first pattern is on cut_in in that same cycle.
- Each pattern is presented for exactly SETTLE_CYCLES cycles. cut_out is sampled on the final edge of that window.
- Run length: PATTERNS×SETTLE_CYCLES cycles with busy=1. done and pass rise on the edge of the last capture, so they are visible the cycle after busy falls.
- pattern_count and signature update on capture edges only.
- start asserted in the same cycle as rst is ignored; rst wins.

## Test plan
- Reset: hold rst 3 cycles mid-RUN → next cycle busy=done=pass=0, cut_in=0, signature=0, pattern_count=0.
- LFSR sequence: SEED=1, SETTLE_CYCLES=1 → cut_in = 0x0000001, 0x0000002, …, 0x2000000 (pattern 25), then 0x0000047 (pattern 26).
- MISR: PATTERNS=2, cut_out tied to 0x00000001 → final signature=0x00000003. With golden_sig=3: pass=1, done=1. With golden_sig=2: pass=0.
- Settle and length: SETTLE_CYCLES=3, PATTERNS=4 → busy high exactly 12 cycles, each pattern held 3 cycles, pattern_count steps 0→4, done asserts after the 12th busy cycle.
- Abort: abort during pattern 5 of 1024 → IDLE next cycle, done=0, pattern_count=5. A following start restarts from SEED with pattern_count=0.
- Live CUT: connect the f1/f8 benchmark netlist, PATTERNS=1024 → signature matches the software model's golden value and pass=1. Flipping one CUT output bit via a force gives pass=0.
